// File: rtl/minmax_pkg.sv
// Shared constants for the polynomial min/max sweep controller.
// FSM encoding, default widths and evaluator flag width.
package minmax_pkg;

  localparam int W_DEF       = 32;
  localparam int STEP_W_DEF  = 16;
  localparam int TIMEOUT_DEF = 256;
  localparam int FLAG_W      = 2;
  localparam int SKIP_W      = 16;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ISSUE  = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_UPDATE = 3'd3;
  localparam logic [2:0] S_NEXT   = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

endpackage

// File: rtl/poly_minmax_upd.sv
// Combinational min/max tracker update.
// Strict compares keep the earliest argument on ties.
module minmax_upd
  import minmax_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic         take,
  input  logic [W-1:0] result,
  input  logic [W-1:0] x,
  input  logic         valid,
  input  logic [W-1:0] min_v,
  input  logic [W-1:0] argmin_v,
  input  logic [W-1:0] max_v,
  input  logic [W-1:0] argmax_v,
  output logic         n_valid,
  output logic [W-1:0] n_min,
  output logic [W-1:0] n_argmin,
  output logic [W-1:0] n_max,
  output logic [W-1:0] n_argmax
);

  always_comb begin
    n_valid  = valid;
    n_min    = min_v;
    n_argmin = argmin_v;
    n_max    = max_v;
    n_argmax = argmax_v;
    if (take) begin
      if (!valid) begin
        n_valid  = 1'b1;
        n_min    = result;
        n_argmin = x;
        n_max    = result;
        n_argmax = x;
      end else begin
        if ($signed(result) < $signed(min_v)) begin
          n_min    = result;
          n_argmin = x;
        end
        if ($signed(result) > $signed(max_v)) begin
          n_max    = result;
          n_argmax = x;
        end
      end
    end
  end

endmodule

// File: rtl/poly_minmax_sweep.sv
// Sweep controller: steps x over [x_lo, x_hi], drives the evaluator,
// and tracks min/max of valid results with their arguments.
module poly_minmax_sweep
  import minmax_pkg::*;
#(
  parameter int W       = W_DEF,
  parameter int STEP_W  = STEP_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [W-1:0]      x_lo,
  input  logic [W-1:0]      x_hi,
  input  logic [STEP_W-1:0] x_step,
  output logic              poly_start_out,
  output logic [W-1:0]      poly_arg_out,
  input  logic              poly_ready_in,
  input  logic [FLAG_W-1:0] poly_ovf_in,
  input  logic [W-1:0]      poly_result_in,
  output logic              busy,
  output logic              done,
  output logic              valid_out,
  output logic              error_out,
  output logic [W-1:0]      min_out,
  output logic [W-1:0]      max_out,
  output logic [W-1:0]      argmin_out,
  output logic [W-1:0]      argmax_out,
  output logic [SKIP_W-1:0] skip_cnt_out
);

  localparam int TW = $clog2(TIMEOUT + 1);

  logic [2:0]        state;
  logic [W-1:0]      x;
  logic [W-1:0]      x_hi_r;
  logic [STEP_W-1:0] step_r;
  logic [TW-1:0]     tmo;
  logic              ready_q;
  logic              rdy_edge;
  logic [W:0]        sum;
  logic              sum_stop;
  logic              take;
  logic              n_valid;
  logic [W-1:0]      n_min;
  logic [W-1:0]      n_argmin;
  logic [W-1:0]      n_max;
  logic [W-1:0]      n_argmax;

  assign poly_start_out = (state == S_ISSUE);
  assign poly_arg_out   = x;
  assign rdy_edge       = poly_ready_in & ~ready_q;
  assign take           = (state == S_UPDATE) && (poly_ovf_in == '0);

  // W+1-bit sum catches both passing x_hi and leaving the signed range
  assign sum = {x[W-1], x} + {{(W + 1 - STEP_W){1'b0}}, step_r};
  assign sum_stop = (sum[W] ^ sum[W-1]) ||
                    ($signed(sum) > $signed({x_hi_r[W-1], x_hi_r}));

  minmax_upd #(.W(W)) u_upd (
    .take     (take),
    .result   (poly_result_in),
    .x        (x),
    .valid    (valid_out),
    .min_v    (min_out),
    .argmin_v (argmin_out),
    .max_v    (max_out),
    .argmax_v (argmax_out),
    .n_valid  (n_valid),
    .n_min    (n_min),
    .n_argmin (n_argmin),
    .n_max    (n_max),
    .n_argmax (n_argmax)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= S_IDLE;
      x            <= '0;
      x_hi_r       <= '0;
      step_r       <= '0;
      tmo          <= '0;
      ready_q      <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      valid_out    <= 1'b0;
      error_out    <= 1'b0;
      min_out      <= '0;
      max_out      <= '0;
      argmin_out   <= '0;
      argmax_out   <= '0;
      skip_cnt_out <= '0;
    end else begin
      ready_q <= poly_ready_in;
      done    <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            x            <= x_lo;
            x_hi_r       <= x_hi;
            step_r       <= (x_step == '0) ? STEP_W'(1) : x_step;
            busy         <= 1'b1;
            valid_out    <= 1'b0;
            error_out    <= 1'b0;
            skip_cnt_out <= '0;
            min_out      <= '0;
            max_out      <= '0;
            argmin_out   <= '0;
            argmax_out   <= '0;
            state <= ($signed(x_lo) > $signed(x_hi)) ? S_DONE : S_ISSUE;
          end
        end
        S_ISSUE: begin
          tmo   <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (rdy_edge) begin
            state <= S_UPDATE;
          end else if (tmo == TW'(TIMEOUT - 1)) begin
            error_out <= 1'b1;
            state     <= S_DONE;
          end else begin
            tmo <= tmo + 1'b1;
          end
        end
        S_UPDATE: begin
          if (poly_ovf_in != '0) begin
            if (skip_cnt_out != '1)
              skip_cnt_out <= skip_cnt_out + 1'b1;
          end
          valid_out  <= n_valid;
          min_out    <= n_min;
          argmin_out <= n_argmin;
          max_out    <= n_max;
          argmax_out <= n_argmax;
          state      <= S_NEXT;
        end
        S_NEXT: begin
          if (sum_stop) begin
            state <= S_DONE;
          end else begin
            x     <= sum[W-1:0];
            state <= S_ISSUE;
          end
        end
        S_DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_poly_minmax_sweep.sv
// Scoreboard bench for poly_minmax_sweep with a behavioural
// Horner evaluator (c[5] is x^0, c[0] is x^5).
module tb_poly_minmax_sweep;

  localparam int W       = 32;
  localparam int STEP_W  = 16;
  localparam int TIMEOUT = 256;
  localparam int LAT     = 3;

  typedef struct {
    int          pts;
    logic        valid;
    logic        err;
    logic [31:0] mn;
    logic [31:0] amn;
    logic [31:0] mx;
    logic [31:0] amx;
    logic [15:0] skip;
  } exp_t;

  logic              clock = 1'b0;
  logic              reset;
  logic              start;
  logic [W-1:0]      x_lo;
  logic [W-1:0]      x_hi;
  logic [STEP_W-1:0] x_step;
  logic              poly_start_out;
  logic [W-1:0]      poly_arg_out;
  logic              poly_ready_in;
  logic [1:0]        poly_ovf_in;
  logic [W-1:0]      poly_result_in;
  logic              busy;
  logic              done;
  logic              valid_out;
  logic              error_out;
  logic [W-1:0]      min_out;
  logic [W-1:0]      max_out;
  logic [W-1:0]      argmin_out;
  logic [W-1:0]      argmax_out;
  logic [15:0]       skip_cnt_out;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  int   pulses = 0;

  int          c [0:5];
  logic        never_ready = 1'b0;
  logic        ovf_zero    = 1'b0;
  logic [31:0] m_arg;
  int          m_cnt = 0;

  always #5 clock = ~clock;

  poly_minmax_sweep #(.W(W), .STEP_W(STEP_W), .TIMEOUT(TIMEOUT)) dut (
    .clock          (clock),
    .reset          (reset),
    .start          (start),
    .x_lo           (x_lo),
    .x_hi           (x_hi),
    .x_step         (x_step),
    .poly_start_out (poly_start_out),
    .poly_arg_out   (poly_arg_out),
    .poly_ready_in  (poly_ready_in),
    .poly_ovf_in    (poly_ovf_in),
    .poly_result_in (poly_result_in),
    .busy           (busy),
    .done           (done),
    .valid_out      (valid_out),
    .error_out      (error_out),
    .min_out        (min_out),
    .max_out        (max_out),
    .argmin_out     (argmin_out),
    .argmax_out     (argmax_out),
    .skip_cnt_out   (skip_cnt_out)
  );

  function automatic logic [31:0] horner(logic signed [31:0] xv);
    longint acc = 0;
    for (int i = 0; i < 6; i++) acc = acc * longint'(xv) + longint'(c[i]);
    return acc[31:0];
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%h) expected %0d (0x%h)",
               name, $signed(act), act, $signed(exp), exp);
    end
  endtask

  // Evaluator model: ready drops on start, rises LAT cycles later
  initial begin
    poly_ready_in  = 1'b0;
    poly_ovf_in    = 2'b00;
    poly_result_in = '0;
    forever begin
      @(negedge clock);
      if (reset) begin
        poly_ready_in = 1'b0;
        m_cnt = 0;
      end else if (poly_start_out) begin
        poly_ready_in = 1'b0;
        m_arg = poly_arg_out;
        m_cnt = LAT;
      end else if (m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 0 && !never_ready) begin
          poly_result_in = horner(m_arg);
          poly_ovf_in    = (ovf_zero && m_arg == 0) ? 2'b01 : 2'b00;
          poly_ready_in  = 1'b1;
        end
      end
    end
  end

  // Monitor: compare a finished sweep against the oldest expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (reset) begin
        pulses = 0;
      end else begin
        if (poly_start_out) pulses++;
        if (done) begin
          if (sb.size() == 0) begin
            chk("unexpected_done", 32'd1, 32'd0);
          end else begin
            e = sb.pop_front();
            chk("points", pulses, e.pts);
            chk("valid", {31'd0, valid_out}, {31'd0, e.valid});
            chk("error", {31'd0, error_out}, {31'd0, e.err});
            chk("skip", {16'd0, skip_cnt_out}, {16'd0, e.skip});
            chk("busy_at_done", {31'd0, busy}, 32'd0);
            if (e.valid) begin
              chk("min", min_out, e.mn);
              chk("argmin", argmin_out, e.amn);
              chk("max", max_out, e.mx);
              chk("argmax", argmax_out, e.amx);
            end
          end
          pulses = 0;
        end
      end
    end
  end

  task automatic launch(int lo, int hi, int st, exp_t e);
    @(negedge clock);
    x_lo   = lo;
    x_hi   = hi;
    x_step = st[15:0];
    start  = 1'b1;
    sb.push_back(e);
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_done(int bound, output int lat);
    lat = 1;
    while (!done && lat < bound) begin
      @(negedge clock);
      lat++;
    end
    if (!done) chk("done_timeout", 32'd0, 32'd1);
    @(negedge clock);
  endtask

  function automatic exp_t mk(int pts, logic v, logic er, int mn, int amn,
                              int mx, int amx, int sk);
    exp_t e;
    e.pts = pts; e.valid = v; e.err = er;
    e.mn = mn; e.amn = amn; e.mx = mx; e.amx = amx; e.skip = sk[15:0];
    return e;
  endfunction

  initial begin
    int lat;
    reset  = 1'b1;
    start  = 1'b0;
    x_lo   = '0;
    x_hi   = '0;
    x_step = '0;
    for (int i = 0; i < 6; i++) c[i] = 0;
    repeat (3) @(negedge clock);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_min", min_out, 32'd0);
    chk("rst_skip", {16'd0, skip_cnt_out}, 32'd0);
    reset = 1'b0;

    // 1: constant 7 at a single point
    c[5] = 7;
    launch(10, 10, 1, mk(1, 1, 0, 7, 10, 7, 10, 0));
    chk("busy_after_start", {31'd0, busy}, 32'd1);
    wait_done(100, lat);

    // 2: x^2 over -3..3, tie at 9 keeps -3
    c[5] = 0; c[3] = 1;
    launch(-3, 3, 1, mk(7, 1, 0, 0, 0, 9, -3, 0));
    wait_done(200, lat);

    // 3: empty range
    launch(5, 4, 1, mk(0, 0, 0, 0, 0, 0, 0, 0));
    wait_done(20, lat);
    chk("empty_latency", lat, 32'd2);

    // 4: evaluator never answers
    never_ready = 1'b1;
    launch(0, 0, 1, mk(1, 0, 1, 0, 0, 0, 0, 0));
    wait_done(TIMEOUT + 50, lat);
    chk("timeout_latency", lat, TIMEOUT + 3);
    never_ready = 1'b0;

    // 5: x=0 flagged invalid
    ovf_zero = 1'b1;
    launch(-3, 3, 1, mk(7, 1, 0, 1, -1, 9, -3, 1));
    wait_done(200, lat);
    ovf_zero = 1'b0;

    // step 0 behaves as step 1: x^2 over 1..2
    launch(1, 2, 0, mk(2, 1, 0, 1, 1, 4, 2, 0));
    wait_done(100, lat);

    // 6: reset mid-sweep, then a sweep at the top of the range
    launch(-3, 3, 1, mk(7, 1, 0, 0, 0, 9, -3, 0));
    repeat (10) @(negedge clock);
    reset = 1'b1;
    sb.delete();
    repeat (2) @(negedge clock);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_valid", {31'd0, valid_out}, 32'd0);
    chk("mid_rst_min", min_out, 32'd0);
    chk("mid_rst_argmax", argmax_out, 32'd0);
    chk("mid_rst_arg", poly_arg_out, 32'd0);
    chk("mid_rst_pstart", {31'd0, poly_start_out}, 32'd0);
    reset = 1'b0;
    launch(32'h7fffffff, 32'h7fffffff, 100,
           mk(1, 1, 0, 1, 32'h7fffffff, 1, 32'h7fffffff, 0));
    wait_done(100, lat);

    repeat (3) @(negedge clock);
    chk("sb_drained", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
